// File: rtl/div_pkg.sv
// Shared types and helpers for the sequential signed divider.
package div_pkg;

  typedef enum logic [1:0] {IDLE, CALC, FIX} div_state_t;

  // Widest operand abs_ext can handle; callers zero-extend into this width.
  localparam int ABS_W = 32;

  // Magnitude of a w-bit two's-complement value held in the low bits of v.
  // Result is w+1 bits wide in effect, so |MIN| = 2^(w-1) is representable.
  function automatic logic [ABS_W:0] abs_ext(input logic [ABS_W-1:0] v, input int w);
    logic [ABS_W:0] lim;
    logic [ABS_W:0] x;
    lim = (ABS_W+1)'(1) << w;
    x   = {1'b0, v} & (lim - (ABS_W+1)'(1));
    if (x >= (lim >> 1)) abs_ext = lim - x;
    else                 abs_ext = x;
  endfunction

endpackage

// File: rtl/div_step.sv
// One restoring division step: shift in the next dividend bit, trial-subtract.
module div_step #(
  parameter int W = 5
) (
  input  logic [W-1:0] rem_i,
  input  logic         bit_i,
  input  logic [W-1:0] dvsr_i,
  output logic [W-1:0] rem_o,
  output logic         q_o
);

  logic [W:0] sh;

  always_comb begin
    sh    = {rem_i, bit_i};
    q_o   = (sh >= {1'b0, dvsr_i});
    rem_o = q_o ? W'(sh - {1'b0, dvsr_i}) : W'(sh);
  end

endmodule

// File: rtl/div_seq.sv
// Sequential signed restoring divider, M cycles of iteration plus a sign-fix cycle.
// Optional macro DIV_ZERO_FAST_EN: B==0 skips the iteration and finishes in one cycle.
module div_seq
  import div_pkg::*;
#(
  parameter int M = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic [M-1:0] A,
  input  logic [M-1:0] B,
  output logic [M-1:0] Q,
  output logic [M-1:0] R,
  output logic         busy,
  output logic         done,
  output logic         C,
  output logic         N,
  output logic         V,
  output logic         Z
);

  localparam int           CW    = $clog2(M + 1);
  localparam logic [M-1:0] MIN_V = {1'b1, {(M-1){1'b0}}};

  div_state_t   state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [M:0]   rem_q, rem_d;
  logic [M:0]   dvsr_q, dvsr_d;
  logic [M-1:0] dvd_q, dvd_d;
  logic [M-1:0] a_q, a_d;
  logic         sa_q, sa_d, sb_q, sb_d, bz_q, bz_d, ovf_q, ovf_d;

  logic [M-1:0] q_q, q_d, r_q, r_d;
  logic         busy_q, busy_d, done_q, done_d;
  logic         c_q, c_d, n_q, n_d, v_q, v_d, z_q, z_d;

  logic [M:0]   a_mag, b_mag;
  logic [M:0]   step_rem;
  logic         step_q;
  logic [M-1:0] q_sgn, r_sgn;

  always_comb begin
    a_mag = (M+1)'(abs_ext(ABS_W'(A), M));
    b_mag = (M+1)'(abs_ext(ABS_W'(B), M));
  end

  div_step #(.W(M + 1)) u_step (
    .rem_i  (rem_q),
    .bit_i  (dvd_q[M-1]),
    .dvsr_i (dvsr_q),
    .rem_o  (step_rem),
    .q_o    (step_q)
  );

  // The dividend register doubles as the quotient: bits leave at the top, quotient bits enter at the bottom.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    rem_d   = rem_q;
    dvsr_d  = dvsr_q;
    dvd_d   = dvd_q;
    a_d     = a_q;
    sa_d    = sa_q;
    sb_d    = sb_q;
    bz_d    = bz_q;
    ovf_d   = ovf_q;
    q_d     = q_q;
    r_d     = r_q;
    c_d     = c_q;
    n_d     = n_q;
    v_d     = v_q;
    z_d     = z_q;
    done_d  = 1'b0;
    q_sgn   = (sa_q ^ sb_q) ? (~dvd_q + 1'b1) : dvd_q;
    r_sgn   = sa_q ? (~M'(rem_q) + 1'b1) : M'(rem_q);

    case (state_q)
      IDLE: begin
        if (start) begin
          a_d     = A;
          sa_d    = A[M-1];
          sb_d    = B[M-1];
          bz_d    = (B == '0);
          ovf_d   = (A == MIN_V) && (B == '1);
          dvsr_d  = b_mag;
          dvd_d   = M'(a_mag);
          rem_d   = '0;
          cnt_d   = CW'(M);
          state_d = CALC;
`ifdef DIV_ZERO_FAST_EN
          if (B == '0) state_d = FIX;
`endif
        end
      end
      CALC: begin
        rem_d = step_rem;
        dvd_d = {dvd_q[M-2:0], step_q};
        cnt_d = cnt_q - 1'b1;
        if (cnt_q == CW'(1)) state_d = FIX;
      end
      FIX: begin
        if (bz_q) begin
          q_d = '1;
          r_d = a_q;
          c_d = 1'b1;
          n_d = 1'b1;
          v_d = 1'b0;
          z_d = 1'b0;
        end else begin
          // MIN / -1 wraps naturally to MIN here; only V needs forcing.
          q_d = q_sgn;
          r_d = r_sgn;
          c_d = 1'b0;
          n_d = q_sgn[M-1];
          v_d = ovf_q;
          z_d = (q_sgn == '0);
        end
        done_d  = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      rem_q   <= '0;
      dvsr_q  <= '0;
      dvd_q   <= '0;
      a_q     <= '0;
      sa_q    <= 1'b0;
      sb_q    <= 1'b0;
      bz_q    <= 1'b0;
      ovf_q   <= 1'b0;
      q_q     <= '0;
      r_q     <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      c_q     <= 1'b0;
      n_q     <= 1'b0;
      v_q     <= 1'b0;
      z_q     <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rem_q   <= rem_d;
      dvsr_q  <= dvsr_d;
      dvd_q   <= dvd_d;
      a_q     <= a_d;
      sa_q    <= sa_d;
      sb_q    <= sb_d;
      bz_q    <= bz_d;
      ovf_q   <= ovf_d;
      q_q     <= q_d;
      r_q     <= r_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      c_q     <= c_d;
      n_q     <= n_d;
      v_q     <= v_d;
      z_q     <= z_d;
    end
  end

  assign Q    = q_q;
  assign R    = r_q;
  assign busy = busy_q;
  assign done = done_q;
  assign C    = c_q;
  assign N    = n_q;
  assign V    = v_q;
  assign Z    = z_q;

endmodule

// File: tb/tb_div_seq.sv
// Self-checking bench for div_seq: vector table, control corner cases, sweep and random ops.
module tb_div_seq;

  localparam int M  = 4;
  localparam int PW = 2*M + 4;

  logic         clk = 1'b0;
  logic         rst_n, start;
  logic [M-1:0] A, B, Q, R;
  logic         busy, done, C, N, V, Z;

  always #5 clk = ~clk;

  div_seq #(.M(M)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .A(A), .B(B),
    .Q(Q), .R(R), .busy(busy), .done(done), .C(C), .N(N), .V(V), .Z(Z)
  );

  int checks = 0;
  int errors = 0;

  typedef struct {
    int a, b, q, r;
    bit c, n, v, z;
  } vec_t;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  function automatic logic [PW-1:0] pack(input int q, input int r, input bit c, input bit n,
                                         input bit v, input bit z);
    pack = {M'(q), M'(r), c, n, v, z};
  endfunction

  function automatic int exp_lat(input int b);
`ifdef DIV_ZERO_FAST_EN
    exp_lat = (b == 0) ? 1 : M + 1;
`else
    exp_lat = M + 1 + 0 * b;
`endif
  endfunction

  // Reference: language-level truncating division plus the two exception rules.
  task automatic ref_div(input int a, input int b, output int q, output int r,
                         output bit c, output bit n, output bit v, output bit z);
    int mn;
    mn = -(1 << (M - 1));
    c = 0; n = 0; v = 0; z = 0;
    if (b == 0) begin
      q = -1; r = a; c = 1; n = 1;
    end else if (a == mn && b == -1) begin
      q = mn; r = 0; v = 1; n = 1;
    end else begin
      q = a / b; r = a % b; n = (q < 0); z = (q == 0);
    end
  endtask

  function automatic logic [PW-1:0] dut_pack();
    dut_pack = {Q, R, C, N, V, Z};
  endfunction

  // Issue one op; returns cycles from accepting edge to done (0 on timeout).
  task automatic run_op(input int a, input int b, output int lat);
    @(negedge clk);
    A = M'(a); B = M'(b); start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    chk("busy_after_accept", busy, 1);
    lat = 0;
    for (int i = 1; i <= 20; i++) begin
      @(posedge clk); #1;
      if (done) begin lat = i; break; end
    end
    if (lat != 0) chk("busy_at_done", busy, 0);
  endtask

  task automatic model_op(input string nm, input int a, input int b, input bit inv);
    int lat, q, r, qi, ri;
    bit c, n, v, z, ok;
    run_op(a, b, lat);
    ref_div(a, b, q, r, c, n, v, z);
    chk({nm, "_lat"}, lat, exp_lat(b));
    chk({nm, "_res"}, dut_pack(), pack(q, r, c, n, v, z));
    if (inv && b != 0 && !(a == -(1 << (M-1)) && b == -1)) begin
      qi = int'($signed(Q)); ri = int'($signed(R));
      ok = (a == qi * b + ri) && ((ri < 0 ? -ri : ri) < (b < 0 ? -b : b)) &&
           (ri == 0 || ((ri < 0) == (a < 0)));
      chk({nm, "_inv"}, ok, 1);
    end
  endtask

  vec_t vecs[12];

  initial begin
    int lat, ndone, gap;
    vecs[0]  = '{7, 2, 3, 1, 0, 0, 0, 0};
    vecs[1]  = '{-7, 2, -3, -1, 0, 1, 0, 0};
    vecs[2]  = '{7, -2, -3, 1, 0, 1, 0, 0};
    vecs[3]  = '{-7, -2, 3, -1, 0, 0, 0, 0};
    vecs[4]  = '{-8, -1, -8, 0, 0, 1, 1, 0};
    vecs[5]  = '{-8, 1, -8, 0, 0, 1, 0, 0};
    vecs[6]  = '{5, 0, -1, 5, 1, 1, 0, 0};
    vecs[7]  = '{0, 3, 0, 0, 0, 0, 0, 1};
    vecs[8]  = '{2, 5, 0, 2, 0, 0, 0, 1};
    vecs[9]  = '{-8, 0, -1, -8, 1, 1, 0, 0};
    vecs[10] = '{7, 7, 1, 0, 0, 0, 0, 0};
    vecs[11] = '{-8, 3, -2, -2, 0, 1, 0, 0};

    rst_n = 1'b0; start = 1'b0; A = '0; B = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_state", {Q, R, busy, done, C, N, V, Z}, 0);
    rst_n = 1'b1;

    foreach (vecs[i]) begin
      run_op(vecs[i].a, vecs[i].b, lat);
      chk($sformatf("vec%0d_lat", i), lat, exp_lat(vecs[i].b));
      chk($sformatf("vec%0d_res", i), dut_pack(),
          pack(vecs[i].q, vecs[i].r, vecs[i].c, vecs[i].n, vecs[i].v, vecs[i].z));
    end

    // Re-pulsed start with new operands while busy must be ignored.
    @(negedge clk);
    A = 4'd7; B = 4'd2; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    A = 4'b1000; B = 4'b1111; start = 1'b1;
    lat = 0;
    for (int i = 3; i <= 20; i++) begin
      @(posedge clk); #1;
      start = 1'b0;
      if (done) begin lat = i; break; end
    end
    chk("repulse_lat", lat, M + 1);
    chk("repulse_res", dut_pack(), pack(3, 1, 0, 0, 0, 0));
    ndone = 0;
    repeat (6) begin @(posedge clk); #1; if (done) ndone++; end
    chk("repulse_single_done", ndone, 0);
    chk("repulse_hold", dut_pack(), pack(3, 1, 0, 0, 0, 0));

    // Reset in the second CALC cycle aborts and clears everything.
    @(negedge clk);
    A = 4'b1001; B = 4'd2; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    chk("abort_hold_prev", dut_pack(), pack(3, 1, 0, 0, 0, 0));
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b0;
    @(posedge clk); #1;
    chk("abort_cleared", {Q, R, busy, done, C, N, V, Z}, 0);
    rst_n = 1'b1;
    ndone = 0;
    repeat (10) begin @(posedge clk); #1; if (done || busy) ndone++; end
    chk("abort_no_done", ndone, 0);

    // Exhaustive back-to-back sweep of all operand pairs.
    for (int a = -(1 << (M-1)); a < (1 << (M-1)); a++)
      for (int b = -(1 << (M-1)); b < (1 << (M-1)); b++)
        model_op($sformatf("sweep_%0d_%0d", a, b), a, b, 1'b1);

    // Random operands with random idle gaps.
    for (int i = 0; i < 60; i++) begin
      gap = $urandom_range(0, 2);
      repeat (gap) @(posedge clk);
      model_op($sformatf("rand%0d", i),
               int'($urandom_range(0, 15)) - 8, int'($urandom_range(0, 15)) - 8, 1'b0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/div_seq.md
# div_seq

Sequential signed integer divider for the ALU datapath, the inverse operation of the combinational multiplier. It accepts an M-bit signed dividend and divisor on a start pulse. It runs a restoring shift-subtract loop on operand magnitudes for M cycles, applies sign correction, and presents quotient, remainder and C/N/V/Z flags with a one-cycle done pulse. Results are truncated toward zero and hold until the next completed operation.

## Interface
- M, default 4: operand, quotient and remainder width in bits (M >= 2).
- clk  in  1  single clock; all state updates on rising edge.
- rst_n  in  1  reset, synchronous, active-low.
- start  in  1  request; sampled only in IDLE.
- A  in  M  signed dividend.
- B  in  M  signed divisor.
- Q  out  M  signed quotient.
- R  out  M  signed remainder.
- busy  out  1  high from the cycle after start acceptance until done is asserted.
- done  out  1  one-cycle pulse when Q/R/flags update.
- C  out  1  divide-by-zero.
- N  out  1  Q negative.
- V  out  1  overflow (most-negative / -1).
- Z  out  1  Q == 0.

## Operation
- Reset state: state=IDLE; Q, R, busy, done, C, N, V and Z are all 0.
- States:
  - IDLE: on start=1, latch |A|, |B|, sign(A), sign(B), B==0 and the A==MIN&&B==-1 condition, clear the partial remainder, load the iteration counter with M, and go to CALC.
  - CALC: one restoring step per cycle, MSB first. Shift {rem, dividend} left by 1, trial-subtract |B|, keep the result if it is non-negative, and set the quotient bit. Decrement the counter; when the counter reaches 0, go to FIX.
  - FIX: apply signs and write outputs. Quotient is negated if sign(A)!=sign(B). Remainder is negated if sign(A)=1. Assert done and go to IDLE.
- Magnitudes use M+1-bit internal width so |MIN| = 2^(M-1) is representable.
- Divide by zero (B==0):
  - Q = all ones (-1), R = A.
  - C=1, V=0, N=1, Z=0.
- Overflow (A==MIN, B==-1):
  - Q = MIN (wrapped), R = 0.
  - V=1, C=0, N=1, Z=0.
- Normal operation: C=0, V=0, N=Q[M-1], Z=(Q==0).
- Invariant for all non-exceptional operands: A == Q*B + R, |R| < |B|, and R has the sign of A or is 0.
- start while busy is ignored; operands are not re-sampled.
- A, B and start changing during CALC have no effect.
- rst_n=0 mid-operation aborts the operation and returns everything to reset values; no done pulse is produced.

## Timing
- Start accepted at edge k (state IDLE, start=1).
- busy=1 after edge k through edge k+M; state is CALC for edges k+1..k+M.
- Q/R/flags update and done=1 after edge k+M+1; busy=0 at the same time. Latency is therefore M+1 cycles from the accepting edge.
- done is high for exactly one cycle.
- A new start can be accepted in the same cycle done is high (state is IDLE). Back-to-back throughput is one operation per M+2 cycles.
- Outputs are registered and stable between done pulses.

## Configuration
- DIV_ZERO_FAST_EN defined:
  - B==0 at acceptance goes IDLE to FIX directly.
  - done follows 1 cycle after the accepting edge; busy is high for that one cycle only.
- DIV_ZERO_FAST_EN undefined: latency is a constant M+1 cycles for all operands, including B==0.
- Result values and flags are identical in both builds.

## Structure
- Shared package div_pkg holds:
  - typedef enum logic [1:0] {IDLE, CALC, FIX} div_state_t.
  - helper function abs_ext (M-bit signed to M+1-bit magnitude), parameterized by the caller width.
- Sub-module div_step: combinational single restoring iteration.
  - Inputs: partial remainder, next dividend bit, divisor magnitude.
  - Outputs: new partial remainder, quotient bit.
  - Instantiated once in div_seq.

## Test plan
- M=4, A=7, B=2 -> after M+1=5 cycles done=1: Q=3, R=1, C=0, N=0, V=0, Z=0.
- A=-7, B=2 -> Q=-3, R=-1, N=1. Then A=7, B=-2 -> Q=-3, R=1. Then A=-7, B=-2 -> Q=3, R=-1.
- A=-8, B=-1 -> Q=-8, R=0, V=1, N=1, C=0. Also A=-8, B=1 -> Q=-8, V=0.
- A=5, B=0 -> Q=-1, R=5, C=1. done after 5 cycles without DIV_ZERO_FAST_EN, after 1 cycle with it.
- A=0, B=3 -> Q=0, R=0, Z=1. A=2, B=5 -> Q=0, R=2, Z=1.
- Control cases:
  - start re-pulsed with new operands while busy: ignored, first result delivered.
  - rst_n=0 at cycle 2 of CALC: all outputs 0 next cycle, no done pulse.
  - Exhaustive sweep of all 256 M=4 operand pairs against the invariant.
